adder_arbiter: RTL

- Shares one N-bit ripple adder (nbit_adder instance) between two requesters.
- Each requester has its own valid/ready operand channel.
- Grants use round-robin arbitration. The granted operands pass through the combinational adder.
- The sum (with carry-out as MSB) and the requester ID are registered into a single-entry output slot, drained by a valid/ready result channel.
- Sits between the operand-producing control logic and any consumer of sums. Gives fair, lossless access to the adder datapath.

---
 rtl/adder_arbiter_if.sv | 53 +++++
 rtl/adder_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_if
// Purpose  : Bundles the two operand channels, the result channel and the
//            per-requester completion counters of adder_arbiter.
// Ports    : (interface signals)
//   req0_valid/req0_a/req0_b/req0_ready : requester 0 operand channel
//   req1_valid/req1_a/req1_b/req1_ready : requester 1 operand channel
//   res_valid/res_s/res_id/res_ready    : result channel (res_s is N+1 bits)
//   busy_cnt0/busy_cnt1                 : 8-bit wrapping completion counters
// Modports : slave  - the arbiter itself
//            master - operand producers / result consumer
// Revision : 1.0 - initial release
// ============================================================================
interface adder_arbiter_if #(
    parameter int N = 4
);
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic [N:0]   res_s;
    logic         res_id;
    logic         res_ready;
    logic [7:0]   busy_cnt0;
    logic [7:0]   busy_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_s, res_id,
        input  res_ready,
        output busy_cnt0, busy_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_s, res_id,
        output res_ready,
        input  busy_cnt0, busy_cnt1
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nbit_adder
// Purpose  : N-bit ripple-carry adder; carry-out is returned as s[N].
// Ports    : a, b (N) operands; cin carry-in; s (N+1) sum with carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module nbit_adder #(
    parameter int N = 4
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    input  wire logic         cin,
    output logic      [N:0]   s
);
    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_full_adder
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign s[N] = carry[N];
endmodule

// ============================================================================
// Module   : adder_arbiter
// Purpose  : Shares one nbit_adder between two requesters using round-robin
//            arbitration; the sum and owner ID are captured in a single-entry
//            result slot drained through a valid/ready channel.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - adder_arbiter_if.slave (operand, result, counter signals)
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int N = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    adder_arbiter_if.slave   bus
);
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         last_grant;
    logic         slot_free;
    logic         grant0;
    logic         grant1;
    logic         xfer;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N:0]   sum;
    logic [N:0]   res_s_q;
    logic         res_id_q;
    logic [7:0]   cnt0_q;
    logic [7:0]   cnt1_q;

    // ------------------------------------------------------------------
    // Round-robin grant. The slot may accept a new operand pair when it is
    // empty or when its current content drains in this same cycle. On a
    // tie the requester that was not served last wins. Grants are forced
    // low while reset is asserted so no handshake completes during reset.
    // ------------------------------------------------------------------
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        slot_free = (state == EMPTY) || bus.res_ready;
        if (rst_n && slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign xfer           = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Only the granted requester's operands reach the shared adder.
    assign add_a = grant1 ? bus.req1_a : bus.req0_a;
    assign add_b = grant1 ? bus.req1_b : bus.req0_b;

    nbit_adder #(
        .N (N)
    ) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (1'b0),
        .s   (sum)
    );

    // Slot occupancy: a transfer always leaves the slot full (including the
    // pass-through case where the old result drains in the same cycle).
    always_comb begin
        state_next = state;
        if (xfer) begin
            state_next = FULL;
        end else if ((state == FULL) && bus.res_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Result slot, arbitration history and completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_s_q    <= '0;
            res_id_q   <= 1'b0;
            last_grant <= 1'b1;
            cnt0_q     <= 8'd0;
            cnt1_q     <= 8'd0;
        end else if (xfer) begin
            res_s_q    <= sum;
            res_id_q   <= grant1;
            last_grant <= grant1;
            if (grant1) begin
                cnt1_q <= cnt1_q + 8'd1;
            end else begin
                cnt0_q <= cnt0_q + 8'd1;
            end
        end
    end

    assign bus.res_valid = (state == FULL);
    assign bus.res_s     = res_s_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy_cnt0 = cnt0_q;
    assign bus.busy_cnt1 = cnt1_q;
endmodule
`default_nettype wire
